// File: rtl/core_pkg.sv
// Shared encodings for the MEM-stage load/store unit.
package core_pkg;

  // Access size from Funct3[1:0]; Funct3[2] selects zero-extension for loads.
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  // Encodings that need special treatment (RV64-only or never legal).
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_INV = 3'b111;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_GNT   = 2'd1,
    WAIT_RDATA = 2'd2
  } lsu_state_e;

  // Width of the byte offset inside one XLEN-wide memory word.
  function automatic int off_w(input int xlen);
    return $clog2(xlen / 8);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables/replication, misalignment detect,
// and load data shift plus sign/zero extension.
module lsu_align
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]             f3_i,
  input  logic [off_w(XLEN)-1:0] off_i,
  input  logic [XLEN-1:0]        wdata_i,
  output logic [XLEN/8-1:0]      be_o,
  output logic [XLEN-1:0]        wdata_o,
  output logic                   misalign_o,
  output size_e                  size_o,
  output logic                   uns_o,
  input  logic [off_w(XLEN)-1:0] ld_off_i,
  input  size_e                  ld_size_i,
  input  logic                   ld_uns_i,
  input  logic [XLEN-1:0]        rdata_i,
  output logic [XLEN-1:0]        ldata_o
);
  localparam int NB = XLEN / 8;
  localparam int OW = off_w(XLEN);

  logic [NB-1:0]   mask;
  logic [OW-1:0]   amask;
  logic            illegal;
  logic [XLEN-1:0] sh;

  // Request side: decode size, build lane mask, check alignment, replicate data.
  always_comb begin
    size_o  = size_e'(f3_i[1:0]);
    uns_o   = f3_i[2];
    illegal = (f3_i == F3_INV) | ((XLEN == 32) & ((f3_i == F3_LD) | (f3_i == F3_LWU)));
    amask   = OW'((4'd1 << size_o) - 4'd1);
    mask    = '0;
    wdata_o = wdata_i;
    case (size_o)
      SZ_B: begin mask = NB'(1);    wdata_o = {NB{wdata_i[7:0]}};        end
      SZ_H: begin mask = NB'(3);    wdata_o = {(NB/2){wdata_i[15:0]}};   end
      SZ_W: begin mask = NB'(4'hF); wdata_o = {(NB/4){wdata_i[31:0]}};   end
      default: begin mask = '1;     wdata_o = wdata_i;                   end
    endcase
    be_o       = mask << off_i;
    misalign_o = illegal | ((off_i & amask) != '0);
  end

  // Response side: bring the addressed lane down to bit 0 and extend it.
  always_comb begin
    sh = rdata_i >> {ld_off_i, 3'b000};
    case (ld_size_i)
      SZ_B:    ldata_o = ld_uns_i ? XLEN'(sh[7:0])  : XLEN'($signed(sh[7:0]));
      SZ_H:    ldata_o = ld_uns_i ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]));
      SZ_W:    ldata_o = ld_uns_i ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]));
      default: ldata_o = sh;
    endcase
  end

endmodule

// File: rtl/memory_stage_lsu.sv
// MEM stage with req/gnt/rvalid data-memory port and the MEM/WB register.
module memory_stage_lsu
  import core_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ValidM,
  input  logic              RegWriteM,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic [2:0]        Funct3M,
  input  logic [REG_W-1:0]  RD_M,
  input  logic [XLEN-1:0]   PCPlus4M,
  input  logic [XLEN-1:0]   ALU_ResultM,
  input  logic [XLEN-1:0]   WriteDataM,
  output logic              StallM,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [XLEN/8-1:0] dm_be,
  output logic [XLEN-1:0]   dm_wdata,
  input  logic              dm_gnt,
  input  logic              dm_rvalid,
  input  logic [XLEN-1:0]   dm_rdata,
  output logic              ValidW,
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcW,
  output logic [REG_W-1:0]  RD_W,
  output logic [XLEN-1:0]   PCPlus4W,
  output logic [XLEN-1:0]   ALU_ResultW,
  output logic [XLEN-1:0]   ReadDataW,
  output logic              MisalignW
);
  localparam int NB = XLEN / 8;
  localparam int OW = off_w(XLEN);

  lsu_state_e      state_q, state_d;
  logic [OW-1:0]   ld_off_q, ld_off_d;
  size_e           ld_size_q, ld_size_d;
  logic            ld_uns_q, ld_uns_d;

  logic            mis, memop, is_load, aligned_op, retire;
  size_e           cur_size;
  logic            cur_uns;
  logic [XLEN-1:0] ldata;

  lsu_align #(.XLEN(XLEN)) u_align (
    .f3_i       (Funct3M),
    .off_i      (ALU_ResultM[OW-1:0]),
    .wdata_i    (WriteDataM),
    .be_o       (dm_be),
    .wdata_o    (dm_wdata),
    .misalign_o (mis),
    .size_o     (cur_size),
    .uns_o      (cur_uns),
    .ld_off_i   (ld_off_q),
    .ld_size_i  (ld_size_q),
    .ld_uns_i   (ld_uns_q),
    .rdata_i    (dm_rdata),
    .ldata_o    (ldata)
  );

  assign dm_addr = ADDR_W'(ALU_ResultM) & ~ADDR_W'(NB - 1);
  assign dm_we   = MemWriteM;

  // Handshake FSM: decides request, retirement, and the load fields to remember.
  always_comb begin
    memop      = ValidM & (MemReadM | MemWriteM);
    is_load    = MemReadM & ~MemWriteM;
    aligned_op = memop & ~mis;
    state_d    = state_q;
    ld_off_d   = ld_off_q;
    ld_size_d  = ld_size_q;
    ld_uns_d   = ld_uns_q;
    dm_req     = 1'b0;
    retire     = ~memop | mis;
    case (state_q)
      IDLE, WAIT_GNT: begin
        // Gated by reset so a held memop is not granted while resetting.
        dm_req  = aligned_op & rst;
        state_d = IDLE;
        if (aligned_op) begin
          if (!dm_gnt) begin
            state_d = WAIT_GNT;
          end else if (MemWriteM) begin
            retire = 1'b1;
          end else begin
            state_d   = WAIT_RDATA;
            ld_off_d  = ALU_ResultM[OW-1:0];
            ld_size_d = cur_size;
            ld_uns_d  = cur_uns;
          end
        end
      end
      WAIT_RDATA: begin
        if (dm_rvalid) begin
          retire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    StallM = ValidM & ~retire;
  end

  // FSM state, latched load fields, and the MEM/WB register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      ld_off_q    <= '0;
      ld_size_q   <= SZ_B;
      ld_uns_q    <= 1'b0;
      ValidW      <= 1'b0;
      RegWriteW   <= 1'b0;
      ResultSrcW  <= '0;
      RD_W        <= '0;
      PCPlus4W    <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
      MisalignW   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_off_q  <= ld_off_d;
      ld_size_q <= ld_size_d;
      ld_uns_q  <= ld_uns_d;
      if (ValidM & retire) begin
        ValidW      <= 1'b1;
        RegWriteW   <= RegWriteM & ~MemWriteM & ~(memop & mis);
        ResultSrcW  <= ResultSrcM;
        RD_W        <= RD_M;
        PCPlus4W    <= PCPlus4M;
        ALU_ResultW <= ALU_ResultM;
        ReadDataW   <= (aligned_op & is_load) ? ldata : '0;
        MisalignW   <= memop & mis;
      end else begin
        ValidW    <= 1'b0;
        RegWriteW <= 1'b0;
        MisalignW <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage_lsu.sv
// Directed bench for memory_stage_lsu: one XLEN=32 and one XLEN=64 instance
// share stimulus; a per-instance scoreboard checks every retired WB slot.
module tb_memory_stage_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        sel64 = 1'b0;
  logic        ValidM = 1'b0, RegWriteM = 1'b0, MemReadM = 1'b0, MemWriteM = 1'b0;
  logic [1:0]  ResultSrcM = '0;
  logic [2:0]  Funct3M = '0;
  logic [4:0]  RD_M = '0;
  logic [63:0] PCPlus4M = '0, ALU_ResultM = '0, WriteDataM = '0, dm_rdata = '0;
  logic        dm_gnt = 1'b0, dm_rvalid = 1'b0;

  logic        s_stall, s_req, s_we, s_vw, s_rww, s_misw;
  logic [31:0] s_addr, s_wdata, s_pcw, s_aluw, s_rdataw;
  logic [3:0]  s_be;
  logic [1:0]  s_rsw;
  logic [4:0]  s_rdw;

  logic        l_stall, l_req, l_we, l_vw, l_rww, l_misw;
  logic [31:0] l_addr;
  logic [63:0] l_wdata, l_pcw, l_aluw, l_rdataw;
  logic [7:0]  l_be;
  logic [1:0]  l_rsw;
  logic [4:0]  l_rdw;

  memory_stage_lsu #(.XLEN(32), .ADDR_W(32), .REG_W(5)) dut32 (
    .clk(clk), .rst(rst), .ValidM(ValidM & ~sel64), .RegWriteM(RegWriteM),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .Funct3M(Funct3M), .RD_M(RD_M), .PCPlus4M(PCPlus4M[31:0]),
    .ALU_ResultM(ALU_ResultM[31:0]), .WriteDataM(WriteDataM[31:0]),
    .StallM(s_stall), .dm_req(s_req), .dm_we(s_we), .dm_addr(s_addr),
    .dm_be(s_be), .dm_wdata(s_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .dm_rdata(dm_rdata[31:0]), .ValidW(s_vw), .RegWriteW(s_rww),
    .ResultSrcW(s_rsw), .RD_W(s_rdw), .PCPlus4W(s_pcw), .ALU_ResultW(s_aluw),
    .ReadDataW(s_rdataw), .MisalignW(s_misw)
  );

  memory_stage_lsu #(.XLEN(64), .ADDR_W(32), .REG_W(5)) dut64 (
    .clk(clk), .rst(rst), .ValidM(ValidM & sel64), .RegWriteM(RegWriteM),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .Funct3M(Funct3M), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
    .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
    .StallM(l_stall), .dm_req(l_req), .dm_we(l_we), .dm_addr(l_addr),
    .dm_be(l_be), .dm_wdata(l_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .dm_rdata(dm_rdata), .ValidW(l_vw), .RegWriteW(l_rww),
    .ResultSrcW(l_rsw), .RD_W(l_rdw), .PCPlus4W(l_pcw), .ALU_ResultW(l_aluw),
    .ReadDataW(l_rdataw), .MisalignW(l_misw)
  );

  wire        m_stall = sel64 ? l_stall : s_stall;
  wire        m_req   = sel64 ? l_req   : s_req;
  wire        m_we    = sel64 ? l_we    : s_we;
  wire [31:0] m_addr  = sel64 ? l_addr  : s_addr;
  wire [7:0]  m_be    = sel64 ? l_be    : {4'b0, s_be};
  wire [63:0] m_wdata = sel64 ? l_wdata : {32'b0, s_wdata};

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [63:0] pc;
    logic [63:0] alu;
    logic [63:0] rdata;
    logic        chk_rdata;
    logic        mis;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon_cmp(input bit is64, input logic rww, input logic [1:0] rsw,
                         input logic [4:0] rdw, input logic [63:0] pcw,
                         input logic [63:0] aluw, input logic [63:0] rdataw,
                         input logic misw);
    exp_t e;
    if ((is64 && q64.size() == 0) || (!is64 && q32.size() == 0)) begin
      checks++;
      failures++;
      $display("FAIL unexpected_retire dut%0d rd=%0d", is64 ? 64 : 32, rdw);
      return;
    end
    if (is64) e = q64.pop_front();
    else      e = q32.pop_front();
    chk("RegWriteW", {63'b0, rww}, {63'b0, e.rw});
    chk("ResultSrcW", {62'b0, rsw}, {62'b0, e.rs});
    chk("RD_W", {59'b0, rdw}, {59'b0, e.rd});
    chk("PCPlus4W", pcw, e.pc);
    chk("ALU_ResultW", aluw, e.alu);
    chk("MisalignW", {63'b0, misw}, {63'b0, e.mis});
    if (e.chk_rdata) chk("ReadDataW", rdataw, e.rdata);
  endtask

  // Monitors: every valid WB slot must match the head of its scoreboard.
  always @(negedge clk) begin
    if (s_vw === 1'b1)
      mon_cmp(1'b0, s_rww, s_rsw, s_rdw, {32'b0, s_pcw}, {32'b0, s_aluw}, {32'b0, s_rdataw}, s_misw);
    else if (s_vw === 1'b0)
      chk("bubble32 RegWriteW", {63'b0, s_rww}, 64'd0);
    if (l_vw === 1'b1)
      mon_cmp(1'b1, l_rww, l_rsw, l_rdw, l_pcw, l_aluw, l_rdataw, l_misw);
    else if (l_vw === 1'b0)
      chk("bubble64 RegWriteW", {63'b0, l_rww}, 64'd0);
  end

  // Issue one MEM-stage instruction and drive the memory handshake for it.
  task automatic op(input logic s64, input logic rw, input logic rd, input logic wr,
                    input logic [1:0] rs, input logic [2:0] f3, input logic [4:0] ridx,
                    input logic [63:0] addr, input logic [63:0] wd,
                    input int gdly, input int rvdly, input logic [63:0] rdata,
                    input logic expmis, input logic [7:0] exp_be,
                    input logic [31:0] exp_addr, input logic [63:0] exp_wd,
                    input logic [63:0] exp_rdata);
    exp_t e;
    int   stalls;
    sel64 = s64; ValidM = 1'b1; RegWriteM = rw; MemReadM = rd; MemWriteM = wr;
    ResultSrcM = rs; Funct3M = f3; RD_M = ridx; ALU_ResultM = addr; WriteDataM = wd;
    PCPlus4M = 64'h100 + 64'(ridx) * 4;
    e.rw = rw & ~wr & ~expmis; e.rs = rs; e.rd = ridx; e.pc = PCPlus4M; e.alu = addr;
    e.rdata = exp_rdata; e.chk_rdata = rd & ~expmis; e.mis = expmis;
    if (s64) q64.push_back(e);
    else     q32.push_back(e);
    stalls = 0;
    if ((rd | wr) && !expmis) begin
      dm_gnt = 1'b0;
      for (int i = 0; i < gdly; i++) begin
        @(negedge clk);
        chk("dm_req while waiting gnt", {63'b0, m_req}, 64'd1);
        if (m_stall) stalls++;
        @(posedge clk); #1;
      end
      dm_gnt = 1'b1;
      @(negedge clk);
      chk("dm_req", {63'b0, m_req}, 64'd1);
      chk("dm_we", {63'b0, m_we}, {63'b0, wr});
      chk("dm_addr", {32'b0, m_addr}, {32'b0, exp_addr});
      chk("dm_be", {56'b0, m_be}, {56'b0, exp_be});
      if (wr) chk("dm_wdata", m_wdata, exp_wd);
      if (m_stall) stalls++;
      @(posedge clk); #1;
      dm_gnt = 1'b0;
      if (rd) begin
        for (int i = 1; i < rvdly; i++) begin
          @(negedge clk);
          chk("dm_req in WAIT_RDATA", {63'b0, m_req}, 64'd0);
          if (m_stall) stalls++;
          @(posedge clk); #1;
        end
        dm_rvalid = 1'b1; dm_rdata = rdata;
        @(negedge clk);
        if (m_stall) stalls++;
        @(posedge clk); #1;
        dm_rvalid = 1'b0;
      end
      chk("StallM cycles", 64'(stalls), rd ? 64'(gdly + rvdly) : 64'(gdly));
    end else begin
      @(negedge clk);
      chk("dm_req none", {63'b0, m_req}, 64'd0);
      chk("StallM none", {63'b0, m_stall}, 64'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    ValidM = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_w_zero(input string tag);
    chk({tag, " W32"}, {s_vw, s_rww, s_rsw, s_rdw, s_misw, s_pcw | s_aluw | s_rdataw}, 64'd0);
    chk({tag, " W64"}, {53'b0, l_vw, l_rww, l_rsw, l_rdw, l_misw} | l_pcw | l_aluw | l_rdataw, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk_w_zero("reset");
    chk("reset dm_req32", {63'b0, s_req}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    //  s64 rw rd wr rs     f3      rd  addr        wdata        g  rv rdata                 mis be          addr        exp_wd                 exp_rdata
    op(0, 1, 0, 0, 2'b00, 3'b000,  5, 64'h1234,   64'h0,        0, 0, 64'h0,                0, 8'h00,      32'h0,      64'h0,                 64'h0);
    op(0, 1, 0, 1, 2'b00, 3'b000,  3, 64'h1003,   64'hAB,       0, 0, 64'h0,                0, 8'b1000,    32'h1000,   64'hABABABAB,          64'h0);
    op(0, 1, 1, 0, 2'b01, 3'b001,  7, 64'h2002,   64'h0,        2, 1, 64'h80010000,         0, 8'b1100,    32'h2000,   64'h0,                 64'hFFFF8001);
    op(0, 1, 1, 0, 2'b01, 3'b101,  8, 64'h2002,   64'h0,        2, 1, 64'h80010000,         0, 8'b1100,    32'h2000,   64'h0,                 64'h00008001);
    op(0, 1, 1, 0, 2'b01, 3'b010, 10, 64'h3001,   64'h0,        0, 0, 64'h0,                1, 8'h00,      32'h0,      64'h0,                 64'h0);
    op(0, 1, 0, 0, 2'b00, 3'b000, 11, 64'h55,     64'h0,        0, 0, 64'h0,                0, 8'h00,      32'h0,      64'h0,                 64'h0);
    op(0, 1, 1, 0, 2'b01, 3'b100, 12, 64'h4001,   64'h0,        0, 1, 64'h0000F700,         0, 8'b0010,    32'h4000,   64'h0,                 64'h000000F7);
    op(0, 0, 0, 1, 2'b00, 3'b010, 13, 64'h5004,   64'h12345678, 1, 0, 64'h0,                0, 8'b1111,    32'h5004,   64'h12345678,          64'h0);
    op(0, 0, 0, 1, 2'b00, 3'b001, 14, 64'h6002,   64'hBEEF,     0, 0, 64'h0,                0, 8'b1100,    32'h6000,   64'hBEEFBEEF,          64'h0);
    op(0, 1, 1, 0, 2'b01, 3'b000, 15, 64'h7003,   64'h0,        0, 3, 64'h80000000,         0, 8'b1000,    32'h7000,   64'h0,                 64'hFFFFFF80);
    op(0, 1, 1, 0, 2'b01, 3'b011, 16, 64'h8,      64'h0,        0, 0, 64'h0,                1, 8'h00,      32'h0,      64'h0,                 64'h0);
    op(0, 1, 0, 0, 2'b00, 3'b000, 17, 64'h99,     64'h0,        0, 0, 64'h0,                0, 8'h00,      32'h0,      64'h0,                 64'h0);

    // Load granted, then reset while waiting for data; late rvalid must be ignored.
    sel64 = 1'b0; ValidM = 1'b1; RegWriteM = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0;
    Funct3M = 3'b010; RD_M = 5'd20; ALU_ResultM = 64'h9000; dm_gnt = 1'b1;
    @(posedge clk); #1;
    dm_gnt = 1'b0; ValidM = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; dm_rvalid = 1'b1; dm_rdata = 64'h11112222;
    @(negedge clk);
    chk_w_zero("mid-load reset");
    chk("dm_req after reset", {63'b0, s_req}, 64'd0);
    @(posedge clk); #1;
    dm_rvalid = 1'b0;
    idle(2);
    op(0, 1, 1, 0, 2'b01, 3'b010, 21, 64'h9004,   64'h0,        0, 1, 64'hCAFEBABE,         0, 8'b1111,    32'h9004,   64'h0,                 64'hCAFEBABE);

    op(1, 1, 1, 0, 2'b01, 3'b011, 22, 64'h8,      64'h0,        1, 2, 64'h1122334455667788, 0, 8'hFF,      32'h8,      64'h0,                 64'h1122334455667788);
    op(1, 1, 1, 0, 2'b01, 3'b110, 23, 64'h4,      64'h0,        0, 1, 64'hCAFEF00D12345678, 0, 8'hF0,      32'h0,      64'h0,                 64'h00000000CAFEF00D);
    op(1, 1, 1, 0, 2'b01, 3'b010, 24, 64'h4,      64'h0,        0, 1, 64'hCAFEF00D12345678, 0, 8'hF0,      32'h0,      64'h0,                 64'hFFFFFFFFCAFEF00D);
    op(1, 0, 0, 1, 2'b00, 3'b001, 25, 64'hA,      64'hBEEF,     0, 0, 64'h0,                0, 8'b00001100, 32'h8,     64'hBEEFBEEFBEEFBEEF,  64'h0);
    op(1, 1, 1, 0, 2'b01, 3'b011, 26, 64'hC,      64'h0,        0, 0, 64'h0,                1, 8'h00,      32'h0,      64'h0,                 64'h0);
    idle(3);

    chk("scoreboard drained", 64'(q32.size() + q64.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_stage_lsu.md
Name: memory_stage_lsu

Overview:
- Parametrised MEM stage plus MEM/WB pipeline register for the 5-stage RISC-V core.
- Replaces the single-cycle, word-only data-memory path with the following:
  - an external request/grant/rvalid data-memory interface;
  - byte/halfword/word (and doubleword at XLEN=64) load/store with byte enables and load sign/zero extension;
  - misalignment detection;
  - a stall output back to the hazard unit.
- Sits between the EX/MEM register and the writeback mux.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- ADDR_W, 32, data-memory byte-address width.
- REG_W, 5, register index width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-low reset
- ValidM  in  1  instruction present in MEM
- RegWriteM  in  1  writes destination register
- MemReadM  in  1  load
- MemWriteM  in  1  store
- ResultSrcM  in  2  writeback mux select (passed through)
- Funct3M  in  3  access size/sign
- RD_M  in  REG_W  destination index
- PCPlus4M  in  XLEN  return address
- ALU_ResultM  in  XLEN  effective address / ALU result
- WriteDataM  in  XLEN  store data
- StallM  out  1  MEM cannot retire this cycle; hold IF..MEM
- dm_req  out  1  memory request
- dm_we  out  1  write request
- dm_addr  out  ADDR_W  XLEN/8-aligned address
- dm_be  out  XLEN/8  byte enables
- dm_wdata  out  XLEN  lane-replicated store data
- dm_gnt  in  1  request accepted this cycle
- dm_rvalid  in  1  read data valid
- dm_rdata  in  XLEN  read data
- ValidW  out  1  WB slot valid
- RegWriteW  out  1  WB register write enable
- ResultSrcW  out  2  WB mux select
- RD_W  out  REG_W  WB destination index
- PCPlus4W  out  XLEN  WB return address
- ALU_ResultW  out  XLEN  WB ALU result
- ReadDataW  out  XLEN  WB extended load data
- MisalignW  out  1  WB instruction faulted; RegWriteW forced 0

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE;
  - all W outputs 0;
  - dm_req=0 next cycle.
  - Reset mid-transaction abandons it; a late dm_rvalid arriving in IDLE is ignored.
- Memop = ValidM & (MemReadM | MemWriteM).
- Size decode from Funct3M:
  - 000/100 byte;
  - 001/101 half;
  - 010/110 word;
  - 011 double.
  - Bit2 = zero-extend.
  - 011 and 110 are legal only when XLEN=64; otherwise they are flagged misaligned.
- Misaligned: addr offset not a multiple of size. Result:
  - no dm_req;
  - instruction retires in 1 cycle with MisalignW=1, RegWriteW=0.
- Request signals (combinational):
  - dm_addr = ALU_ResultM with low log2(XLEN/8) bits cleared.
  - dm_be = size mask << offset.
  - dm_wdata = store data replicated across lanes.
- FSM states: IDLE, WAIT_GNT, WAIT_RDATA.
  - IDLE: dm_req = aligned memop.
    - gnt & store -> retire, stay IDLE.
    - gnt & load -> latch offset/size/sign, go WAIT_RDATA.
    - No gnt -> WAIT_GNT.
  - WAIT_GNT: dm_req held high with identical fields; upstream inputs are frozen by StallM.
    - gnt -> same as the IDLE gnt transitions.
  - WAIT_RDATA: dm_req=0. dm_rvalid -> retire, go IDLE. rvalid is never accepted in the gnt cycle; minimum load latency is 2 cycles.
- StallM = ~(retire condition) whenever ValidM; it is combinational.
  - Retire conditions: non-memop, misaligned, store&gnt, or load&rvalid in WAIT_RDATA.
- W register update on each posedge:
  - on retire, captures the M fields and extended load data;
  - on stall, or when ValidM=0, loads a bubble (ValidW=0, RegWriteW=0, other fields don't-care but held).
- Load extension:
  - rdata >> (offset*8);
  - then sign- or zero-extend from 8/16/32 bits to XLEN.
- Stores never write a register, regardless of RegWriteM.

Decomposition:
- Shared package core_pkg:
  - Funct3 size/sign encodings;
  - FSM state enum;
  - XLEN-derived byte-offset width constant.
- One sub-module, lsu_align:
  - purely combinational;
  - generates byte enables and store-lane replication;
  - detects misalignment;
  - shifts and extends load data.

Test Plan:
- Reset asserted mid-WAIT_RDATA with rvalid one cycle later -> state IDLE, all W outputs 0, rvalid ignored, no write.
- SB addr 0x1003, data 0x000000AB, gnt same cycle -> dm_be=1000, dm_wdata=0xABABABAB, StallM=0, ValidW=1, RegWriteW=0 next cycle.
- LH addr 0x2002, gnt delayed 2 cycles, rvalid 1 cycle after gnt, rdata 0x8001_0000 -> StallM high 3 cycles, W bubbles meanwhile, ReadDataW=0xFFFF8001.
- LHU same stimulus -> ReadDataW=0x00008001.
- LW addr 0x3001 -> no dm_req, StallM=0, MisalignW=1, RegWriteW=0.
- Back-to-back ADD then LBU addr 0x4001 (rdata 0x0000F700) -> ADD retires next cycle, LBU ReadDataW=0x000000F7.
- XLEN=64: LD addr 0x8 and LWU addr 0x4 -> full 64-bit data and zero-extended upper half respectively.
